// File: rtl/timer_pkg.sv
// Shared types and constants for the interval timer controller.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} timer_state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Control/status bundle between a timer client (master) and the timer (slave).
interface interval_timer_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) ();

  logic             start;
  logic             stop;
  logic             hold;
  logic             mode;
  logic [WIDTH-1:0] period;
  logic [PRE_W-1:0] prescale;
  logic             busy;
  logic             tick;
  logic             done;
  logic [WIDTH-1:0] count_out;

  modport master (
    output start, stop, hold, mode, period, prescale,
    input  busy, tick, done, count_out
  );

  modport slave (
    input  start, stop, hold, mode, period, prescale,
    output busy, tick, done, count_out
  );

endinterface

// File: rtl/timer_prescaler.sv
// Clock divider: emits a one-cycle step whenever the enabled count reaches div.
module timer_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [PRE_W-1:0] div,
  output logic             step
);

  logic [PRE_W-1:0] cnt;

  assign step = en && (cnt == div);

  // Wrap is by compare only, so div never needs to be a power of two minus one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == div) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer: FSM plus step counter driven by the prescaler's step pulse.
module interval_timer_ctrl #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  interval_timer_ctrl_if.slave bus
);

  import timer_pkg::*;

  timer_state_t     state;
  logic [WIDTH-1:0] period_l;
  logic [WIDTH-1:0] count;
  logic [PRE_W-1:0] prescale_l;
  logic             mode_l;
  logic             tick_r;
  logic             done_r;
  logic             step;
  logic             active;
  logic             pre_clr;
  logic             pre_en;

  assign active  = (state == RUN) || (state == HOLD);
  assign pre_clr = (state == IDLE) || bus.stop;
  // The edge that leaves HOLD already counts, so HOLD and RUN share one enable.
  assign pre_en  = active && !bus.stop && !bus.hold;

  timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .div  (prescale_l),
    .step (step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      period_l   <= '0;
      prescale_l <= '0;
      mode_l     <= MODE_ONESHOT;
      count      <= '0;
      tick_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      tick_r <= 1'b0;
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop && (bus.period != '0)) begin
            period_l   <= bus.period;
            prescale_l <= bus.prescale;
            mode_l     <= bus.mode;
            count      <= '0;
            state      <= RUN;
          end
        end
        RUN, HOLD: begin
          if (bus.stop) begin
            count <= '0;
            state <= IDLE;
          end else if (bus.hold) begin
            state <= HOLD;
          end else begin
            state <= RUN;
            if (step) begin
              if (count == period_l - 1'b1) begin
                count  <= '0;
                tick_r <= 1'b1;
                if (mode_l == MODE_ONESHOT) begin
                  done_r <= 1'b1;
                  state  <= IDLE;
                end
              end else begin
                count <= count + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = active;
  assign bus.tick      = tick_r;
  assign bus.done      = done_r;
  assign bus.count_out = count;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Randomized and directed bench for interval_timer_ctrl against an elapsed-time model.
module tb_interval_timer_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  interval_timer_ctrl_if #(.WIDTH(8), .PRE_W(4)) bus ();

  interval_timer_ctrl #(.WIDTH(8), .PRE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: time is the number of non-held active edges since start.
  bit m_active;
  bit m_mode;
  int m_period;
  int m_pre;
  int m_elapsed;
  bit m_tick;
  bit m_done;

  task automatic model_reset();
    m_active  = 0;
    m_mode    = 0;
    m_period  = 0;
    m_pre     = 0;
    m_elapsed = 0;
    m_tick    = 0;
    m_done    = 0;
  endtask

  task automatic model_edge();
    m_tick = 0;
    m_done = 0;
    if (rst) begin
      model_reset();
    end else if (!m_active) begin
      if (bus.start && !bus.stop && bus.period != 0) begin
        m_active  = 1;
        m_mode    = bus.mode;
        m_period  = int'(bus.period);
        m_pre     = int'(bus.prescale);
        m_elapsed = 0;
      end
    end else if (bus.stop) begin
      m_active  = 0;
      m_elapsed = 0;
    end else if (!bus.hold) begin
      m_elapsed++;
      if (m_elapsed % (m_period * (m_pre + 1)) == 0) begin
        m_tick = 1;
        if (!m_mode) begin
          m_done   = 1;
          m_active = 0;
        end
      end
    end
  endtask

  function automatic int model_count();
    if (!m_active) return 0;
    return (m_elapsed / (m_pre + 1)) % m_period;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    check_output({ctx, ".busy"},  32'(bus.busy),      32'(m_active));
    check_output({ctx, ".tick"},  32'(bus.tick),      32'(m_tick));
    check_output({ctx, ".done"},  32'(bus.done),      32'(m_done));
    check_output({ctx, ".count"}, 32'(bus.count_out), 32'(model_count()));
  endtask

  task automatic apply_stimulus(input bit s, input bit p, input bit h, input bit m,
                                input logic [7:0] per, input logic [3:0] pre, input string ctx);
    @(negedge clk);
    bus.start    = s;
    bus.stop     = p;
    bus.hold     = h;
    bus.mode     = m;
    bus.period   = per;
    bus.prescale = pre;
    @(posedge clk);
    model_edge();
    #1;
    check_all(ctx);
  endtask

  task automatic idle_cycles(input int n, input string ctx);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 8'd0, 4'd0, ctx);
  endtask

  // Reset lands between edges and must take effect without a clock.
  task automatic async_reset(input string ctx);
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all({ctx, ".async"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    bus.start = 0; bus.stop = 0; bus.hold = 0; bus.mode = 0;
    bus.period = '0; bus.prescale = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset.busy",  32'(bus.busy), 0);
    check_output("reset.tick",  32'(bus.tick), 0);
    check_output("reset.done",  32'(bus.done), 0);
    check_output("reset.count", 32'(bus.count_out), 0);
    @(negedge clk);
    rst = 1'b0;

    apply_stimulus(1, 0, 0, 0, 8'd5, 4'd0, "oneshot");
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus(0, 0, 0, 0, 8'd0, 4'd0, "oneshot");
      if (i == 5) begin
        check_output("oneshot.tick_e5", 32'(bus.tick), 1);
        check_output("oneshot.done_e5", 32'(bus.done), 1);
        check_output("oneshot.busy_e5", 32'(bus.busy), 0);
      end
    end
    idle_cycles(2, "oneshot");

    apply_stimulus(1, 0, 0, 1, 8'd3, 4'd2, "periodic");
    idle_cycles(30, "periodic");
    apply_stimulus(0, 1, 0, 0, 8'd0, 4'd0, "periodic_stop");
    idle_cycles(2, "periodic");

    apply_stimulus(1, 0, 0, 1, 8'd4, 4'd0, "hold");
    idle_cycles(2, "hold");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 1, 0, 8'd0, 4'd0, "hold");
      check_output("hold.frozen_count", 32'(bus.count_out), 2);
      check_output("hold.busy", 32'(bus.busy), 1);
    end
    apply_stimulus(0, 0, 0, 0, 8'd0, 4'd0, "hold_exit");
    apply_stimulus(0, 0, 0, 0, 8'd0, 4'd0, "hold_e7");
    check_output("hold.tick_e7", 32'(bus.tick), 1);
    idle_cycles(6, "hold");
    apply_stimulus(0, 1, 0, 0, 8'd0, 4'd0, "hold_stop");

    apply_stimulus(1, 0, 0, 0, 8'd2, 4'd0, "stopexp");
    apply_stimulus(0, 0, 0, 0, 8'd0, 4'd0, "stopexp");
    apply_stimulus(0, 1, 0, 0, 8'd0, 4'd0, "stopexp_e2");
    check_output("stopexp.tick", 32'(bus.tick), 0);
    check_output("stopexp.busy", 32'(bus.busy), 0);
    idle_cycles(3, "stopexp");

    apply_stimulus(1, 0, 0, 1, 8'd0, 4'd3, "period0");
    check_output("period0.busy", 32'(bus.busy), 0);
    idle_cycles(2, "period0");
    apply_stimulus(1, 1, 0, 1, 8'd4, 4'd0, "startstop");
    check_output("startstop.busy", 32'(bus.busy), 0);
    idle_cycles(2, "startstop");

    apply_stimulus(1, 0, 0, 0, 8'd4, 4'd0, "restart");
    apply_stimulus(0, 0, 0, 0, 8'd0, 4'd0, "restart");
    apply_stimulus(1, 0, 0, 1, 8'd9, 4'd5, "restart_ignored");
    idle_cycles(4, "restart");

    apply_stimulus(1, 0, 0, 1, 8'd8, 4'd0, "asyncrst");
    idle_cycles(3, "asyncrst");
    check_output("asyncrst.count3", 32'(bus.count_out), 3);
    async_reset("asyncrst");
    idle_cycles(10, "asyncrst_after");

    apply_stimulus(1, 0, 0, 0, 8'd255, 4'd0, "maxper");
    idle_cycles(257, "maxper");

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset("rand");
      end else begin
        apply_stimulus($urandom_range(0, 7) == 0,
                       $urandom_range(0, 59) == 0,
                       $urandom_range(0, 5) == 0,
                       1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 7)),
                       4'($urandom_range(0, 3)),
                       "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/interval_timer_ctrl.md
Name: interval_timer_ctrl

Overview:
- Programmable interval-timer controller that sequences an enable-gated up-counter.
- A prescaler divides clk into count steps. The counter advances once per step and wraps at a programmed period, emitting a tick.
- Supports one-shot and periodic modes, hold (pause) and stop.
- Used as the scheduling front-end for counter datapaths and as a periodic event source for downstream blocks.

Parameters:
- WIDTH, 8, width of period register and count_out
- PRE_W, 4, width of prescale field (step every prescale+1 clocks)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  pulse; launch timer (sampled in IDLE only)
- stop  input  1  pulse; abort timer, return to IDLE
- hold  input  1  level; freeze prescaler and counter while high
- mode  input  1  0 = one-shot, 1 = periodic (latched at start)
- period  input  WIDTH  steps per interval, latched at start; 0 is illegal
- prescale  input  PRE_W  clocks per step minus 1, latched at start
- busy  output  1  high in RUN or HOLD
- tick  output  1  one-cycle pulse at end of each interval
- done  output  1  one-cycle pulse when a one-shot interval completes (coincident with tick)
- count_out  output  WIDTH  current step count, 0..period-1

Behaviour:
- Clock and reset: one clock. rst is asynchronous and active-high.
- Reset state: FSM = IDLE. Outputs busy = 0, tick = 0, done = 0, count_out = 0. Prescaler = 0. Latched period/prescale/mode = 0.
- FSM states: IDLE, RUN, HOLD. Encoding is defined in the package.
- IDLE:
  - On start=1, stop=0 and period!=0: latch period, prescale and mode; clear count and prescaler; go to RUN.
  - On start with period==0: ignore; stay in IDLE with no outputs asserted.
  - On start and stop in the same cycle: stop wins; stay in IDLE.
- RUN, each clock:
  - If stop: go to IDLE, clear count and prescaler, no tick.
  - Else if hold: go to HOLD; this edge applies no step and no prescaler increment.
  - Else if prescaler==prescale_l: prescaler <= 0 and a step occurs. Otherwise prescaler increments.
- Step:
  - If count==period_l-1: count <= 0 and tick <= 1.
    - In one-shot mode, also done <= 1 and go to IDLE.
    - In periodic mode, stay in RUN.
  - Otherwise count <= count+1.
- HOLD:
  - Count and prescaler are frozen.
  - stop has priority: go to IDLE and clear.
  - hold=0 returns to RUN; counting resumes on the next edge.
  - start is ignored.
- start while in RUN or HOLD is ignored. No re-latch, no restart.
- Latency:
  - start is sampled at edge E0. The first step occurs at edge E0+(prescale+1).
  - tick is high for the cycle following edge E0 + period*(prescale+1), counting hold cycles as not elapsed.
- Output registration: tick and done are registered and high exactly one cycle. busy is decoded from the registered state.
- Width rules: count compares against period_l-1 in WIDTH bits. period = 2^WIDTH-1 is the maximum interval, and count never exceeds period_l-1. Prescaler wraps only via compare, never by overflow.
- Simultaneous events: stop beats step-expiry (no tick, no done). hold beats step.
- Reset mid-operation: immediate return to reset state. Any pending tick or done is dropped.

Decomposition:
- Shared package timer_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, HOLD} timer_state_t
  - constants MODE_ONESHOT = 1'b0 and MODE_PERIODIC = 1'b1
- One sub-module, timer_prescaler:
  - Parameterised on PRE_W.
  - Inputs: clk, rst, clr, en, div.
  - Output: step pulse when the internal count equals div.
  - The FSM and step counter stay in interval_timer_ctrl.

Test Plan:
- Reset, then one-shot: WIDTH=8, period=5, prescale=0, start at E0.
  - Required: tick=done=1 in the cycle after E5.
  - count_out sequence 0,1,2,3,4,0; busy falls in the same cycle.
- Periodic with prescale: period=3, prescale=2.
  - Required: tick every 9 clocks, first after E9; count steps every 3 clocks; done stays 0.
- Hold: periodic, period=4, prescale=0, hold high for 3 cycles after E2.
  - Required: count_out frozen at 2, busy=1, state HOLD; first tick delayed to after E7.
- Stop on expiry edge: period=2, prescale=0, stop asserted at E2.
  - Required: no tick, no done; IDLE with count_out=0, busy=0.
- Illegal and ignored starts:
  - start with period=0 → stays IDLE, no outputs.
  - start during RUN with a new period=9 → ignored; original period=4 interval unchanged.
  - start+stop together in IDLE → stays IDLE.
- Async reset mid-run: assert rst between edges with count=3.
  - Required: count_out=0, busy=0 immediately, without waiting for a clock edge; no tick after release.
